// File: rtl/mem_ctrl_pkg.sv
// rtl/mem_ctrl_pkg.sv - shared constants, op encoding and parity helper for mem_rr_port_ctrl
package mem_ctrl_pkg;

  localparam int MAX_CH     = 8;
  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 2;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_e;

  // Even parity over up to 64 data bits; callers zero-extend narrower words.
  function automatic logic even_parity(input logic [63:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin arbiter with combinational one-hot grant
module rr_arbiter
  import mem_ctrl_pkg::*;
#(
  parameter int N = 2,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          en,
  input  logic [N-1:0]  req,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] ptr
);

  logic [PW-1:0] ptr_q;
  logic [PW-1:0] ptr_d;
  logic          found;

  // Grant the first requester at or above ptr, then wrap to the ones below it.
  always_comb begin
    grant = '0;
    ptr_d = ptr_q;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (en && !found && req[i] && (PW'(i) >= ptr_q)) begin
        found    = 1'b1;
        grant[i] = 1'b1;
        ptr_d    = (i == N - 1) ? '0 : PW'(i + 1);
      end
    end
    for (int i = 0; i < N; i++) begin
      if (en && !found && req[i] && (PW'(i) < ptr_q)) begin
        found    = 1'b1;
        grant[i] = 1'b1;
        ptr_d    = (i == N - 1) ? '0 : PW'(i + 1);
      end
    end
  end

  // Pointer advances past the granted channel; holds when nothing is granted.
  always_ff @(posedge clock) begin
    if (reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/mem_rr_port_ctrl.sv
// rtl/mem_rr_port_ctrl.sv - round-robin multi-channel front end for a single-port array; MEM_PARITY_EN adds a stored parity bit
module mem_rr_port_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 10,
  parameter int NUM_CH = 2,
  parameter int RD_LAT = 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     chip_en,
  input  logic [NUM_CH-1:0]        req_valid,
  input  logic [NUM_CH-1:0]        req_wr,
  input  logic [NUM_CH*ADDR_W-1:0] req_addr,
  input  logic [NUM_CH*DATA_W-1:0] req_wdata,
  output logic [NUM_CH-1:0]        req_ready,
  output logic [NUM_CH-1:0]        rsp_valid,
  output logic [DATA_W-1:0]        rsp_rdata,
  output logic                     rsp_perr,
  input  logic                     perr_inject,
  output logic                     busy
);

`ifdef MEM_PARITY_EN
  localparam int PAR_W = 1;
`else
  localparam int PAR_W = 0;
`endif
  localparam int MW  = DATA_W + PAR_W;
  localparam int IDW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int PW  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  if (NUM_CH < 1 || NUM_CH > MAX_CH) begin : g_bad_num_ch
    $error("NUM_CH out of range");
  end
  if (RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX) begin : g_bad_rd_lat
    $error("RD_LAT out of range");
  end

  logic [MW-1:0]     mem [2**ADDR_W];

  logic [PW-1:0]     rr_ptr;
  logic              acc_rd;
  logic              acc_wr;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic [IDW-1:0]    sel_id;
  op_e               sel_op;
  logic [MW-1:0]     wr_word;

  logic              rsp_vld_q;
  logic [IDW-1:0]    rsp_id_q;
  logic [MW-1:0]     rsp_word_q;

  logic              unused_ok;
  assign unused_ok = ^{rr_ptr, perr_inject};

  rr_arbiter #(
    .N (NUM_CH)
  ) u_arb (
    .clock (clock),
    .reset (reset),
    .en    (chip_en & ~reset),
    .req   (req_valid),
    .grant (req_ready),
    .ptr   (rr_ptr)
  );

  // Steer the granted channel's request onto the single array port.
  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_id    = '0;
    sel_op    = OP_RD;
    acc_rd    = 1'b0;
    acc_wr    = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (req_ready[i]) begin
        sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
        sel_wdata = req_wdata[i*DATA_W +: DATA_W];
        sel_id    = IDW'(i);
        sel_op    = op_e'(req_wr[i]);
      end
    end
    acc_wr = (|req_ready) && (sel_op == OP_WR);
    acc_rd = (|req_ready) && (sel_op == OP_RD);
  end

`ifdef MEM_PARITY_EN
  assign wr_word = {even_parity(64'(sel_wdata)) ^ perr_inject, sel_wdata};
`else
  assign wr_word = sel_wdata;
`endif

  // Array write port; contents survive reset.
  always_ff @(posedge clock) begin
    if (acc_wr) begin
      mem[sel_addr] <= wr_word;
    end
  end

  if (RD_LAT <= RD_LAT_MIN) begin : g_lat1
    // Read result and channel id land directly in the response stage.
    always_ff @(posedge clock) begin
      if (reset) begin
        rsp_vld_q  <= 1'b0;
        rsp_id_q   <= '0;
        rsp_word_q <= '0;
      end else begin
        rsp_vld_q <= acc_rd;
        if (acc_rd) begin
          rsp_id_q   <= sel_id;
          rsp_word_q <= mem[sel_addr];
        end
      end
    end
    assign busy = rsp_vld_q;
  end else begin : g_lat2
    logic           s1_vld_q;
    logic [IDW-1:0] s1_id_q;
    logic [MW-1:0]  s1_word_q;

    // Two-stage read pipeline: array read, then response register.
    always_ff @(posedge clock) begin
      if (reset) begin
        s1_vld_q   <= 1'b0;
        s1_id_q    <= '0;
        s1_word_q  <= '0;
        rsp_vld_q  <= 1'b0;
        rsp_id_q   <= '0;
        rsp_word_q <= '0;
      end else begin
        s1_vld_q  <= acc_rd;
        rsp_vld_q <= s1_vld_q;
        if (acc_rd) begin
          s1_id_q   <= sel_id;
          s1_word_q <= mem[sel_addr];
        end
        if (s1_vld_q) begin
          rsp_id_q   <= s1_id_q;
          rsp_word_q <= s1_word_q;
        end
      end
    end
    assign busy = s1_vld_q | rsp_vld_q;
  end

  // Decode the response channel id into the one-hot strobe.
  always_comb begin
    rsp_valid = '0;
    if (rsp_vld_q) begin
      rsp_valid[rsp_id_q] = 1'b1;
    end
  end

  assign rsp_rdata = rsp_word_q[DATA_W-1:0];

`ifdef MEM_PARITY_EN
  assign rsp_perr = rsp_vld_q &&
                    (even_parity(64'(rsp_word_q[DATA_W-1:0])) != rsp_word_q[DATA_W]);
`else
  assign rsp_perr = 1'b0;
`endif

endmodule

// File: tb/tb_mem_rr_port_ctrl.sv
// tb/tb_mem_rr_port_ctrl.sv - directed self-checking bench for mem_rr_port_ctrl at RD_LAT 1 and 2
module tb_mem_rr_port_ctrl;

  localparam int DW = 16;
  localparam int AW = 10;
  localparam int NC = 2;

`ifdef MEM_PARITY_EN
  localparam logic PERR_EXP = 1'b1;
`else
  localparam logic PERR_EXP = 1'b0;
`endif

  logic             clock = 1'b0;
  logic             reset;
  logic             chip_en;
  logic [NC-1:0]    req_valid;
  logic [NC-1:0]    req_wr;
  logic [AW-1:0]    addr0, addr1;
  logic [DW-1:0]    wdata0, wdata1;
  logic             perr_inject;

  logic [NC-1:0]    rdy1, rdy2, rv1, rv2;
  logic [DW-1:0]    rd1, rd2;
  logic             pe1, pe2, busy1, busy2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  mem_rr_port_ctrl #(.DATA_W(DW), .ADDR_W(AW), .NUM_CH(NC), .RD_LAT(1)) dut1 (
    .clock       (clock),
    .reset       (reset),
    .chip_en     (chip_en),
    .req_valid   (req_valid),
    .req_wr      (req_wr),
    .req_addr    ({addr1, addr0}),
    .req_wdata   ({wdata1, wdata0}),
    .req_ready   (rdy1),
    .rsp_valid   (rv1),
    .rsp_rdata   (rd1),
    .rsp_perr    (pe1),
    .perr_inject (perr_inject),
    .busy        (busy1)
  );

  mem_rr_port_ctrl #(.DATA_W(DW), .ADDR_W(AW), .NUM_CH(NC), .RD_LAT(2)) dut2 (
    .clock       (clock),
    .reset       (reset),
    .chip_en     (chip_en),
    .req_valid   (req_valid),
    .req_wr      (req_wr),
    .req_addr    ({addr1, addr0}),
    .req_wdata   ({wdata1, wdata0}),
    .req_ready   (rdy2),
    .rsp_valid   (rv2),
    .rsp_rdata   (rd2),
    .rsp_perr    (pe2),
    .perr_inject (perr_inject),
    .busy        (busy2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b1; chip_en = 1'b1; req_valid = 2'b11; req_wr = 2'b00;
    addr0 = 10'h010; addr1 = 10'h020; wdata0 = '0; wdata1 = '0; perr_inject = 1'b0;
    #1;
    check("rst_ready_t0", rdy1, 2'b00);

    for (int k = 0; k < 2; k++) begin
      cyc();
      check("rst_ready1", rdy1, 2'b00);
      check("rst_ready2", rdy2, 2'b00);
      check("rst_rv1", rv1, 2'b00);
      check("rst_rv2", rv2, 2'b00);
      check("rst_busy", {busy1, busy2}, 2'b00);
      check("rst_rdata", {rd1, rd2}, 32'h0);
      check("rst_perr", {pe1, pe2}, 2'b00);
    end
    reset = 1'b0;
    #1;
    check("first_grant_ch0", rdy1, 2'b01);

    // Both channels hold reads: grants alternate, responses follow at 1 and 2 cycles.
    for (int k = 1; k <= 4; k++) begin
      cyc();
      check("alt_ready1", rdy1, (k % 2 == 1) ? 2'b10 : 2'b01);
      check("alt_ready2", rdy2, (k % 2 == 1) ? 2'b10 : 2'b01);
      check("alt_rv1", rv1, (k % 2 == 1) ? 2'b01 : 2'b10);
      check("alt_rv2", rv2, (k == 1) ? 2'b00 : ((k % 2 == 1) ? 2'b10 : 2'b01));
      check("alt_busy", {busy1, busy2}, 2'b11);
    end

    // ch0 writes 0x3FF, ch1 reads it the next cycle.
    req_valid = 2'b01; req_wr = 2'b01; addr0 = 10'h3FF; wdata0 = 16'hA5A5;
    #1;
    check("wr_ready", rdy1, 2'b01);
    cyc();
    req_valid = 2'b10; req_wr = 2'b00; addr1 = 10'h3FF;
    #1;
    check("rd_ready_ch1", rdy1, 2'b10);
    cyc();
    req_valid = 2'b00;
    check("raw_rv1", rv1, 2'b10);
    check("raw_rd1", rd1, 16'hA5A5);
    check("raw_rv2_early", rv2, 2'b00);
    cyc();
    check("raw_rv1_done", rv1, 2'b00);
    check("raw_rd1_held", rd1, 16'hA5A5);
    check("raw_rv2", rv2, 2'b10);
    check("raw_rd2", rd2, 16'hA5A5);
    cyc();
    check("idle_busy", {busy1, busy2}, 2'b00);
    check("idle_rv2", rv2, 2'b00);

    // Read accepted, then chip_en drops: response still arrives, no grants.
    req_valid = 2'b01; addr0 = 10'h3FF;
    #1;
    check("ce_ready", rdy1, 2'b01);
    cyc();
    chip_en = 1'b0; req_valid = 2'b11;
    #1;
    check("ce_off_ready", rdy1, 2'b00);
    check("ce_rv1", rv1, 2'b01);
    check("ce_rd1", rd1, 16'hA5A5);
    cyc();
    check("ce_off_ready2", rdy2, 2'b00);
    check("ce_rv2", rv2, 2'b01);
    check("ce_rd2", rd2, 16'hA5A5);
    cyc();
    check("ce_off_ready3", rdy1, 2'b00);
    check("ce_busy", {busy1, busy2}, 2'b00);
    chip_en = 1'b1;
    #1;
    check("ce_ptr_held", rdy1, 2'b10);

    // Read accepted, reset one cycle later: the 2-cycle response is dropped.
    req_valid = 2'b10; addr1 = 10'h3FF;
    cyc();
    reset = 1'b1; req_valid = 2'b00;
    #1;
    check("mid_rst_ready", rdy1, 2'b00);
    check("mid_rst_busy2", busy2, 1'b1);
    check("mid_rst_rv2_pre", rv2, 2'b00);
    cyc();
    check("mid_rst_rv2", rv2, 2'b00);
    check("mid_rst_busy", {busy1, busy2}, 2'b00);
    check("mid_rst_rdata", {rd1, rd2}, 32'h0);
    cyc();
    check("mid_rst_rv2_b", rv2, 2'b00);
    reset = 1'b0;

    // Injected parity error, then a clean write/read of the same address.
    req_valid = 2'b01; req_wr = 2'b01; addr0 = 10'h155; wdata0 = 16'h0001; perr_inject = 1'b1;
    cyc();
    req_wr = 2'b00; perr_inject = 1'b0;
    cyc();
    check("pe_rv1", rv1, 2'b01);
    check("pe_rd1", rd1, 16'h0001);
    check("pe_perr1", pe1, PERR_EXP);
    req_valid = 2'b00;
    cyc();
    check("pe_rv2", rv2, 2'b01);
    check("pe_perr2", pe2, PERR_EXP);
    check("pe_perr1_idle", pe1, 1'b0);
    req_valid = 2'b01; req_wr = 2'b01; wdata0 = 16'h0003;
    cyc();
    req_wr = 2'b00;
    cyc();
    req_valid = 2'b00;
    check("clean_rv1", rv1, 2'b01);
    check("clean_rd1", rd1, 16'h0003);
    check("clean_perr1", pe1, 1'b0);
    cyc();
    check("clean_rv2", rv2, 2'b01);
    check("clean_rd2", rd2, 16'h0003);
    check("clean_perr2", pe2, 1'b0);
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_rr_port_ctrl.md
Name: mem_rr_port_ctrl

Overview:
- Parametrised successor to the fixed 16x1024 single-port memory macro wrapper.
- Arbitrates NUM_CH independent requesters, round-robin, onto one internal single-port array of 2^ADDR_W x DATA_W words.
- Read latency is configurable, and each read response is routed back to the requesting channel.
- Sits between client blocks and memory, replacing per-client direct macro hookup.

Parameters:
- DATA_W, 16, word width in bits.
- ADDR_W, 10, address width; depth = 2^ADDR_W.
- NUM_CH, 2, requester channel count (1..8).
- RD_LAT, 1, read latency in cycles from accept to rsp_valid (legal values 1 or 2).

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- chip_en  in  1  global enable; low blocks new grants.
- req_valid  in  NUM_CH  per-channel request valid.
- req_wr  in  NUM_CH  per-channel op: 1 = write, 0 = read.
- req_addr  in  NUM_CH*ADDR_W  packed addresses; channel i at [i*ADDR_W +: ADDR_W].
- req_wdata  in  NUM_CH*DATA_W  packed write data, same packing.
- req_ready  out  NUM_CH  one-hot grant; the request is accepted when valid&&ready.
- rsp_valid  out  NUM_CH  one-hot read-response strobe.
- rsp_rdata  out  DATA_W  shared read data; meaningful only while any rsp_valid is high.
- rsp_perr  out  1  parity error on the current response (see Optional Feature).
- perr_inject  in  1  test hook: invert stored parity on the accepted write.
- busy  out  1  high while any read is in flight.

Behaviour:
- Reset (clock edge with reset=1):
  - rr pointer = 0.
  - rsp_valid = 0, rsp_rdata = 0, rsp_perr = 0, busy = 0.
  - All in-flight reads are dropped. Array contents are not cleared.
- req_ready is combinational from req_valid, rr pointer and chip_en.
  - It is forced to 0 when chip_en = 0 or reset = 1.
  - At most one bit is high; it is never high for a channel whose req_valid = 0.
- Arbitration:
  - Search starts at channel ptr, ascending with wrap at NUM_CH-1 -> 0.
  - The first valid channel found is granted.
  - After a grant to channel g, ptr <= (g+1) mod NUM_CH. With no grant, ptr holds.
- Write accept: mem[addr] <= wdata at that edge. No response is generated.
- Read accept:
  - Channel id and the array read result are pipelined.
  - rsp_valid[id] pulses for exactly one cycle, RD_LAT cycles after the accept edge.
  - rsp_rdata is held at its last value otherwise.
- Ordering: responses come back in accept order. One access per cycle gives full throughput, e.g. back-to-back reads from alternating channels.
- Write then read to the same address in the next cycle returns the new data. There is no same-cycle hazard because the array is single-port.
- chip_en falling mid-flight: already-accepted reads still complete; no new accepts.
- reset mid-flight: pending rsp_valid pulses are suppressed on the next cycle.
- busy = OR of the pipeline valid bits.
- Requesters must hold req_addr, req_wdata and req_wr stable while req_valid is high and ready is low. A requester may drop req_valid without being served.
- NUM_CH = 1: the arbiter degenerates to ready = valid && chip_en.

Optional Feature:
- Macro: MEM_PARITY_EN.
- Defined:
  - The array is DATA_W+1 bits wide; bit DATA_W stores even parity of wdata, XOR perr_inject.
  - On read, rsp_perr = recomputed parity != stored parity. It is valid only alongside rsp_valid and is 0 otherwise.
- Undefined:
  - The array is DATA_W bits wide.
  - rsp_perr is tied to 0 and perr_inject is ignored.
  - The port list is unchanged.

Decomposition:
- Package mem_ctrl_pkg:
  - localparams MAX_CH = 8, RD_LAT_MIN = 1, RD_LAT_MAX = 2.
  - op enum {OP_RD, OP_WR}.
  - Function for even-parity computation.
- One sub-module, rr_arbiter: parameter N; inputs clock, reset, en, req[N]; outputs grant[N] (one-hot, combinational) and the pointer register.
- The array and the response pipeline stay in the top module.

Test Plan:
- Reset with reset=1 for 2 cycles, all req_valid=1 -> req_ready=0 and rsp_valid=0 during reset. First grant after release goes to ch0.
- NUM_CH=2, both channels hold reads continuously -> grants alternate ch0, ch1, ch0, ...; rsp_valid alternates 01, 10 with RD_LAT delay.
- ch0 writes 0xA5A5 to addr 0x3FF, ch1 reads 0x3FF in the next cycle -> rsp_valid[1] with rsp_rdata = 0xA5A5 after RD_LAT cycles.
- Read issued, then chip_en=0 the next cycle -> that response still arrives; no further req_ready while chip_en=0; ptr unchanged.
- Read accepted, then reset asserted one cycle later with RD_LAT=2 -> no rsp_valid pulse; busy=0 after reset.
- MEM_PARITY_EN, write 0x0001 with perr_inject=1, then read -> rsp_perr=1 with rsp_valid. A clean write and read of the same address gives rsp_perr=0.
